id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Reset is asynchronous and active-low; the block uses one clock and one reset.
REQ-002 Ports, clock and reset first:
 clk  in  1  rising-edge clock
 rst_n  in  1  async active-low reset
 IFID_reg_rs / IFID_reg_rt / IFID_reg_rd  in  5 each  decoded register fields
 IFID_uses_rt  in  1  instruction reads rt as a source
 reg_read_data_1_in / reg_read_data_2_in  in  32 each  register-file read data
 sign_ext_imm_in  in  32  sign-extended immediate
 ctrl_in  in  ctrl_t  decoded controls: regwrite, memread, memwrite, memtoreg, alusrc, regdst, branch, aluop[1:0]
 flush  in  1  branch taken in EX; squash the ID instruction
 hold  in  1  downstream freeze (memory busy)
 IDEX_reg_rs / IDEX_reg_rt / IDEX_reg_rd  out  5 each  registered fields to EX / forwarding
 IDEX_read_data_1 / IDEX_read_data_2 / IDEX_imm  out  32 each  registered operands
 IDEX_ctrl  out  ctrl_t  registered controls
 stall  out  1  comb; deasserts PC write and IF/ID write
 bubble_count  out  16  saturating count of inserted bubbles

Function
REQ-003 Per-edge register-update priority: flush > hold > load-use bubble > normal load.
REQ-004 Load-use hazard, combinational: lu = IDEX_ctrl.memread & (IDEX_reg_rt != 0) & ((IDEX_reg_rt == IFID_reg_rs) | (IFID_uses_rt & (IDEX_reg_rt == IFID_reg_rt))).
REQ-005 stall = (lu | hold) & !flush.
REQ-006 Normal: on clk rise, all IDEX_* outputs load their *_in / IFID_* sources; latency 1 cycle.
REQ-007 Bubble (lu, no flush, no hold): IDEX_ctrl loads all-zero; data/field outputs load normally; the IF/ID instruction is retained by the upstream stall.
REQ-008 hold (no flush): every IDEX_* register keeps its value; no bubble is inserted; bubble_count is unchanged.
REQ-009 flush: IDEX_ctrl loads all-zero, and IDEX_reg_rs/rt/rd load 0, regardless of lu or hold.
REQ-010 A bubble clears IDEX_ctrl.memread, so lu falls the next cycle; a single load yields exactly one bubble cycle.
REQ-011 FSM, 2 states: RUN, BUBBLE.
 - RUN->BUBBLE on lu & !hold & !flush.
 - BUBBLE->RUN unconditionally on the next edge.
 - flush in any state -> RUN.
REQ-012 bubble_count increments by 1 on each RUN->BUBBLE transition, saturates at 16'hFFFF and never wraps.
REQ-013 Register 0 is never a hazard source: IDEX_reg_rt == 0 never raises lu.
REQ-014 Simultaneous lu and hold: hold wins, stall = 1, the FSM stays in RUN, and lu is re-evaluated once hold drops.

Reset
REQ-015 While rst_n = 0, all IDEX_* outputs are 0, bubble_count = 0, and the FSM is in RUN; the effect is immediate, without waiting for clk.
REQ-016 stall = 0 during reset; because outputs are zero, lu = 0.
REQ-017 A reset asserted mid-bubble returns the FSM to RUN with no increment; the first edge after release performs a normal load.

Structure
REQ-018 ctrl_t (packed struct), the ALUOP_* constants and the pipeline-register width parameters live in the shared package cpu_pkg, which the forwarding and EX blocks also use.
REQ-019 The block contains one sub-module, hazard_detect: pure combinational lu/stall logic, instantiated once; the registers and FSM stay at top level.

Verification
REQ-020 lw $5 in ID/EX (memread = 1, rt = 5) with IF/ID add rs = 5 -> stall = 1 for one cycle; next IDEX_ctrl = 0; bubble_count 0 -> 1; following cycle loads the add with stall = 0.
REQ-021 lw with rt = 0 and IF/ID rs = 0 -> stall = 0; no bubble; bubble_count unchanged.
REQ-022 lu and flush in the same cycle -> stall = 0; IDEX_ctrl = 0; IDEX_reg_rs/rt/rd = 0; bubble_count unchanged; FSM = RUN.
REQ-023 hold = 1 for 3 cycles with changing inputs -> all IDEX_* stay constant and stall = 1; on release, the next edge loads the current inputs.
REQ-024 Preload bubble_count = 16'hFFFE, then force 3 load-use events -> count reads FFFF, FFFF, FFFF.
REQ-025 rst_n falls asynchronously mid-bubble, between clock edges -> all outputs are 0 immediately; the first edge after release loads normally with bubble_count = 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types: control bundle, ALU op codes, register widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int CNT_W      = 16;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;  // loads/stores: address add
  localparam logic [1:0] ALUOP_SUB   = 2'b01;  // branches: compare by subtract
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;  // decode from funct field

  typedef struct packed {
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       alusrc;
    logic       regdst;
    logic       branch;
    logic [1:0] aluop;
  } ctrl_t;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_BUBBLE = 1'b1
  } idex_state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle between decode/upstream control and the ID/EX pipeline register.
// Latency: n/a (wires only).
// Backpressure: hold freezes the stage, stall tells upstream to freeze PC and IF/ID.
// Ports: IFID_* / *_in / ctrl_in / flush / hold / preload go into the stage,
//        IDEX_* / stall / bubble_count come out of it.
interface id_ex_stage_if;
  import cpu_pkg::*;

  logic [REG_ADDR_W-1:0] IFID_reg_rs;
  logic [REG_ADDR_W-1:0] IFID_reg_rt;
  logic [REG_ADDR_W-1:0] IFID_reg_rd;
  logic                  IFID_uses_rt;
  logic [DATA_W-1:0]     reg_read_data_1_in;
  logic [DATA_W-1:0]     reg_read_data_2_in;
  logic [DATA_W-1:0]     sign_ext_imm_in;
  ctrl_t                 ctrl_in;
  logic                  flush;
  logic                  hold;
  // Debug/test hook: overwrite the bubble counter on the next edge.
  logic                  bubble_cnt_preload_vld;
  logic [CNT_W-1:0]      bubble_cnt_preload_dat;

  logic [REG_ADDR_W-1:0] IDEX_reg_rs;
  logic [REG_ADDR_W-1:0] IDEX_reg_rt;
  logic [REG_ADDR_W-1:0] IDEX_reg_rd;
  logic [DATA_W-1:0]     IDEX_read_data_1;
  logic [DATA_W-1:0]     IDEX_read_data_2;
  logic [DATA_W-1:0]     IDEX_imm;
  ctrl_t                 IDEX_ctrl;
  logic                  stall;
  logic [CNT_W-1:0]      bubble_count;

  modport master (
    output IFID_reg_rs, IFID_reg_rt, IFID_reg_rd, IFID_uses_rt,
           reg_read_data_1_in, reg_read_data_2_in, sign_ext_imm_in,
           ctrl_in, flush, hold, bubble_cnt_preload_vld, bubble_cnt_preload_dat,
    input  IDEX_reg_rs, IDEX_reg_rt, IDEX_reg_rd,
           IDEX_read_data_1, IDEX_read_data_2, IDEX_imm, IDEX_ctrl,
           stall, bubble_count
  );

  modport slave (
    input  IFID_reg_rs, IFID_reg_rt, IFID_reg_rd, IFID_uses_rt,
           reg_read_data_1_in, reg_read_data_2_in, sign_ext_imm_in,
           ctrl_in, flush, hold, bubble_cnt_preload_vld, bubble_cnt_preload_dat,
    output IDEX_reg_rs, IDEX_reg_rt, IDEX_reg_rd,
           IDEX_read_data_1, IDEX_read_data_2, IDEX_imm, IDEX_ctrl,
           stall, bubble_count
  );

endinterface

// File: rtl/hazard_detect.sv
// Load-use hazard detection and upstream stall generation.
// Latency: combinational.
// Backpressure: o_stall freezes PC/IF/ID on load-use or hold; flush overrides.
// Ports: i_en (low forces stall off), ID/EX load info, IF/ID sources, flush/hold in;
//        o_lu, o_stall out.
module hazard_detect
  import cpu_pkg::*;
(
  input  logic                  i_en,
  input  logic                  i_idex_memread,
  input  logic [REG_ADDR_W-1:0] i_idex_rt,
  input  logic [REG_ADDR_W-1:0] i_ifid_rs,
  input  logic [REG_ADDR_W-1:0] i_ifid_rt,
  input  logic                  i_ifid_uses_rt,
  input  logic                  i_flush,
  input  logic                  i_hold,
  output logic                  o_lu,
  output logic                  o_stall
);

  // $0 is hard-wired, so a load targeting it never produces a real dependency.
  assign o_lu = i_idex_memread & (i_idex_rt != '0) &
                ((i_idex_rt == i_ifid_rs) | (i_ifid_uses_rt & (i_idex_rt == i_ifid_rt)));

  assign o_stall = i_en & (o_lu | i_hold) & ~i_flush;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush and hold.
// Latency: 1 cycle from IF/ID inputs to IDEX_* outputs.
// Backpressure: hold freezes all state; stall asks upstream to freeze PC/IF/ID.
// Ports: clk, rst_n (async active-low), bus (id_ex_stage_if.slave) carrying
//        decode inputs, flush/hold, counter preload, IDEX_* outputs, stall, bubble_count.
module id_ex_stage
  import cpu_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  id_ex_stage_if.slave  bus
);

  logic [REG_ADDR_W-1:0] r_reg_rs;
  logic [REG_ADDR_W-1:0] r_reg_rt;
  logic [REG_ADDR_W-1:0] r_reg_rd;
  logic [DATA_W-1:0]     r_read_data_1;
  logic [DATA_W-1:0]     r_read_data_2;
  logic [DATA_W-1:0]     r_imm;
  ctrl_t                 r_ctrl;
  logic [CNT_W-1:0]      r_bubble_count;
  idex_state_t           r_state;

  idex_state_t           w_state_nxt;
  logic                  w_enter_bubble;
  logic                  w_lu;
  logic                  w_stall;

  hazard_detect u_hazard_detect (
    .i_en           (rst_n),
    .i_idex_memread (r_ctrl.memread),
    .i_idex_rt      (r_reg_rt),
    .i_ifid_rs      (bus.IFID_reg_rs),
    .i_ifid_rt      (bus.IFID_reg_rt),
    .i_ifid_uses_rt (bus.IFID_uses_rt),
    .i_flush        (bus.flush),
    .i_hold         (bus.hold),
    .o_lu           (w_lu),
    .o_stall        (w_stall)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A bubble lasts exactly one edge: it zeroes memread, so lu cannot persist.
  always_comb begin
    w_state_nxt    = ST_RUN;
    w_enter_bubble = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_lu & ~bus.hold & ~bus.flush) begin
          w_state_nxt    = ST_BUBBLE;
          w_enter_bubble = 1'b1;
        end
      end
      ST_BUBBLE: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // Pipeline register: flush > hold > bubble > normal load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reg_rs      <= '0;
      r_reg_rt      <= '0;
      r_reg_rd      <= '0;
      r_read_data_1 <= '0;
      r_read_data_2 <= '0;
      r_imm         <= '0;
      r_ctrl        <= '0;
    end else if (bus.flush) begin
      // Squashed slot: no controls and no register names, so forwarding
      // and hazard logic downstream can never match on it.
      r_reg_rs      <= '0;
      r_reg_rt      <= '0;
      r_reg_rd      <= '0;
      r_read_data_1 <= bus.reg_read_data_1_in;
      r_read_data_2 <= bus.reg_read_data_2_in;
      r_imm         <= bus.sign_ext_imm_in;
      r_ctrl        <= '0;
    end else if (!bus.hold) begin
      r_reg_rs      <= bus.IFID_reg_rs;
      r_reg_rt      <= bus.IFID_reg_rt;
      r_reg_rd      <= bus.IFID_reg_rd;
      r_read_data_1 <= bus.reg_read_data_1_in;
      r_read_data_2 <= bus.reg_read_data_2_in;
      r_imm         <= bus.sign_ext_imm_in;
      // Bubble: the data rides along but has no effect with all controls off.
      r_ctrl        <= w_lu ? '0 : bus.ctrl_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bubble_count <= '0;
    end else if (bus.bubble_cnt_preload_vld) begin
      r_bubble_count <= bus.bubble_cnt_preload_dat;
    end else if (w_enter_bubble) begin
      r_bubble_count <= sat_inc(r_bubble_count);
    end
  end

  assign bus.IDEX_reg_rs      = r_reg_rs;
  assign bus.IDEX_reg_rt      = r_reg_rt;
  assign bus.IDEX_reg_rd      = r_reg_rd;
  assign bus.IDEX_read_data_1 = r_read_data_1;
  assign bus.IDEX_read_data_2 = r_read_data_2;
  assign bus.IDEX_imm         = r_imm;
  assign bus.IDEX_ctrl        = r_ctrl;
  assign bus.stall            = w_stall;
  assign bus.bubble_count     = r_bubble_count;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed hazard scenarios plus random traffic.
// Latency: checks outputs each cycle, 2 time units after the falling edge.
// Backpressure: exercises hold, flush and load-use stalls.
module tb_id_ex_stage;
  import cpu_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  id_ex_stage_if bus();

  id_ex_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        stall;
    ctrl_t       ctrl;
    logic [4:0]  rs, rt, rd;
    logic [31:0] d1, d2, imm;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Stimulus for the upcoming cycle.
  logic [4:0]  s_rs, s_rt, s_rd;
  logic        s_uses_rt;
  logic [31:0] s_d1, s_d2, s_imm;
  ctrl_t       s_ctrl;
  logic        s_flush, s_hold, s_pre_vld, s_rst_n;
  logic [15:0] s_pre_dat;

  // Reference model: contents of the ID/EX register as the architecture sees it.
  ctrl_t       m_ctrl;
  logic [4:0]  m_rs, m_rt, m_rd;
  logic [31:0] m_d1, m_d2, m_imm;
  logic [15:0] m_cnt;

  function automatic ctrl_t ctrl_lw();
    ctrl_t c = '0;
    c.regwrite = 1'b1; c.memread = 1'b1; c.memtoreg = 1'b1; c.alusrc = 1'b1;
    c.aluop = ALUOP_ADD;
    return c;
  endfunction

  function automatic ctrl_t ctrl_add();
    ctrl_t c = '0;
    c.regwrite = 1'b1; c.regdst = 1'b1; c.aluop = ALUOP_RTYPE;
    return c;
  endfunction

  function automatic ctrl_t ctrl_beq();
    ctrl_t c = '0;
    c.branch = 1'b1; c.aluop = ALUOP_SUB;
    return c;
  endfunction

  function automatic logic model_lu();
    return m_ctrl.memread && (m_rt != 5'd0) &&
           ((m_rt == s_rs) || (s_uses_rt && (m_rt == s_rt)));
  endfunction

  task automatic model_clear();
    m_ctrl = '0; m_rs = '0; m_rt = '0; m_rd = '0;
    m_d1 = '0; m_d2 = '0; m_imm = '0; m_cnt = '0;
  endtask

  // What the register should contain after the coming rising edge.
  task automatic model_edge();
    logic lu;
    lu = model_lu();
    if (s_flush) begin
      m_ctrl = '0; m_rs = '0; m_rt = '0; m_rd = '0;
      m_d1 = s_d1; m_d2 = s_d2; m_imm = s_imm;
    end else if (!s_hold) begin
      m_rs = s_rs; m_rt = s_rt; m_rd = s_rd;
      m_d1 = s_d1; m_d2 = s_d2; m_imm = s_imm;
      m_ctrl = lu ? ctrl_t'('0) : s_ctrl;
      if (lu && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
    if (s_pre_vld) m_cnt = s_pre_dat;
  endtask

  task automatic set_instr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                           input logic uses_rt, input ctrl_t c);
    s_rs = rs; s_rt = rt; s_rd = rd; s_uses_rt = uses_rt; s_ctrl = c;
    s_d1 = $urandom; s_d2 = $urandom; s_imm = $urandom;
  endtask

  // Drive one cycle's inputs at the falling edge and queue what the DUT should show.
  task automatic cycle(input string tag);
    exp_t e;
    @(negedge clk);
    rst_n                      = s_rst_n;
    bus.IFID_reg_rs            = s_rs;
    bus.IFID_reg_rt            = s_rt;
    bus.IFID_reg_rd            = s_rd;
    bus.IFID_uses_rt           = s_uses_rt;
    bus.reg_read_data_1_in     = s_d1;
    bus.reg_read_data_2_in     = s_d2;
    bus.sign_ext_imm_in        = s_imm;
    bus.ctrl_in                = s_ctrl;
    bus.flush                  = s_flush;
    bus.hold                   = s_hold;
    bus.bubble_cnt_preload_vld = s_pre_vld;
    bus.bubble_cnt_preload_dat = s_pre_dat;
    if (!s_rst_n) model_clear();
    e.tag   = tag;
    e.stall = s_rst_n && (model_lu() || s_hold) && !s_flush;
    e.ctrl  = m_ctrl; e.rs = m_rs; e.rt = m_rt; e.rd = m_rd;
    e.d1    = m_d1; e.d2 = m_d2; e.imm = m_imm; e.cnt = m_cnt;
    exp_q.push_back(e);
    if (s_rst_n) model_edge();
  endtask

  task automatic chk(input string tag, input string what,
                     input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s.%s: got %h expected %h (t=%0t)", tag, what, act, expv, $time);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk(e.tag, "stall", 32'(bus.stall),            32'(e.stall));
        chk(e.tag, "ctrl",  32'(bus.IDEX_ctrl),        32'(e.ctrl));
        chk(e.tag, "rs",    32'(bus.IDEX_reg_rs),      32'(e.rs));
        chk(e.tag, "rt",    32'(bus.IDEX_reg_rt),      32'(e.rt));
        chk(e.tag, "rd",    32'(bus.IDEX_reg_rd),      32'(e.rd));
        chk(e.tag, "d1",    bus.IDEX_read_data_1,      e.d1);
        chk(e.tag, "d2",    bus.IDEX_read_data_2,      e.d2);
        chk(e.tag, "imm",   bus.IDEX_imm,              e.imm);
        chk(e.tag, "count", 32'(bus.bubble_count),     32'(e.cnt));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_clear();
    s_flush = 1'b0; s_hold = 1'b0; s_pre_vld = 1'b0; s_pre_dat = '0; s_rst_n = 1'b0;
    set_instr(5'd0, 5'd0, 5'd0, 1'b0, '0);

    // Reset: outputs zero and stall low even with hold requested.
    s_hold = 1'b1;
    cycle("reset0");
    cycle("reset1");
    s_hold = 1'b0; s_rst_n = 1'b1;
    cycle("release");

    // Classic lw $5 followed by a dependent add.
    set_instr(5'd1, 5'd5, 5'd0, 1'b0, ctrl_lw());  cycle("lw");
    set_instr(5'd5, 5'd6, 5'd7, 1'b1, ctrl_add()); cycle("lu_stall");
    cycle("lu_bubble");
    set_instr(5'd2, 5'd3, 5'd4, 1'b1, ctrl_add()); cycle("lu_add_loaded");

    // Load into $0 never stalls.
    set_instr(5'd1, 5'd0, 5'd0, 1'b0, ctrl_lw());  cycle("lw_r0");
    set_instr(5'd0, 5'd0, 5'd8, 1'b1, ctrl_add()); cycle("r0_no_stall");
    cycle("r0_after");

    // Load-use together with flush: flush wins.
    set_instr(5'd1, 5'd5, 5'd0, 1'b0, ctrl_lw());  cycle("lw_fl");
    set_instr(5'd5, 5'd6, 5'd7, 1'b1, ctrl_add()); s_flush = 1'b1; cycle("lu_flush");
    s_flush = 1'b0;
    set_instr(5'd9, 5'd10, 5'd11, 1'b0, ctrl_beq()); cycle("flushed");

    // Hold for three cycles with changing inputs, then release.
    set_instr(5'd3, 5'd4, 5'd12, 1'b1, ctrl_add()); cycle("pre_hold");
    s_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_instr(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                1'b1, ctrl_add());
      cycle("hold");
    end
    s_hold = 1'b0;
    set_instr(5'd13, 5'd14, 5'd15, 1'b1, ctrl_add()); cycle("hold_release");
    cycle("hold_loaded");

    // Saturation: preload near the top, then three load-use events.
    s_pre_vld = 1'b1; s_pre_dat = 16'hFFFE;
    set_instr(5'd0, 5'd0, 5'd0, 1'b0, '0); cycle("preload");
    s_pre_vld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_instr(5'd1, 5'd5, 5'd0, 1'b0, ctrl_lw());  cycle("sat_lw");
      set_instr(5'd2, 5'd5, 5'd7, 1'b1, ctrl_add()); cycle("sat_stall");
    end
    set_instr(5'd0, 5'd0, 5'd0, 1'b0, '0); cycle("sat_end");

    // Asynchronous reset arriving between edges while in the bubble.
    set_instr(5'd1, 5'd5, 5'd0, 1'b0, ctrl_lw());  cycle("rst_lw");
    set_instr(5'd5, 5'd6, 5'd7, 1'b1, ctrl_add()); cycle("rst_stall");
    s_rst_n = 1'b0; cycle("rst_mid_bubble");
    s_rst_n = 1'b1; cycle("rst_released");
    set_instr(5'd6, 5'd7, 5'd8, 1'b1, ctrl_add()); cycle("rst_first_load");

    // Random traffic over a small register space to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      logic [8:0] raw;
      raw = 9'($urandom);
      set_instr(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), ctrl_t'(raw));
      s_ctrl.memread = ($urandom_range(0, 1) == 0);
      s_flush   = ($urandom_range(0, 9) == 0);
      s_hold    = ($urandom_range(0, 6) == 0);
      s_pre_vld = ($urandom_range(0, 49) == 0);
      s_pre_dat = ($urandom_range(0, 1) == 0) ? 16'hFFFE : 16'($urandom);
      s_rst_n   = ($urandom_range(0, 99) != 0);
      cycle("random");
    end

    s_flush = 1'b0; s_hold = 1'b0; s_pre_vld = 1'b0; s_rst_n = 1'b1;
    cycle("drain");
    @(negedge clk);
    @(negedge clk);
    #3;
    chk("end", "queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
